count_loader: RTL and testbench
===============================

# count_loader

Sequencer that drives a loadable up-counter through its `load`/`data_in` port and watches the counter's `count` output for a target value. A single `start` handshake programs the counter with a preset, then reports a match, a watchdog timeout, or (optionally) a failed load. It sits on the control side of the loadable counter, with its outputs wired to the counter's load inputs and the counter's `count` wired back into `count_in`.

## Interface
- `W`, default 4: counter data width.
- `TIMEOUT`, default 32: maximum RUN cycles before timeout; legal range 2..255.
- `clk` input 1: single clock; all logic is rising-edge triggered.
- `rst` input 1: reset; asynchronous, active-high.
- `start` input 1: request; sampled only in IDLE.
- `preset` input W: value to load into the counter; captured with `start`.
- `target` input W: value to wait for; captured with `start`.
- `count_in` input W: the counter's current count.
- `load_out` output 1: drives the counter's `load`.
- `data_out` output W: drives the counter's `data_in`.
- `busy` output 1: high from the edge that accepts `start` until the edge that enters IDLE.
- `done` output 1: one-cycle pulse on match.
- `timeout` output 1: one-cycle pulse on watchdog expiry.
- `load_err` output 1: one-cycle pulse on load mismatch; present only with `LOAD_CHECK_EN`.

## Operation
- States:
  - IDLE: `start`=1 at an edge captures `preset` and `target`, then goes to LOAD.
  - LOAD: lasts exactly one cycle, then goes to RUN.
  - RUN: goes to DONE on match, timeout or load error.
  - DONE: lasts one cycle, then goes to IDLE.
- All outputs are registered.
- `load_out`=1 only while in LOAD.
- `data_out` equals the captured preset from LOAD entry until the next capture.
- RUN behaviour:
  - At each edge, compare `count_in` with the captured target; equality means match.
  - An 8-bit watchdog clears on RUN entry and increments each RUN cycle.
  - If the watchdog equals TIMEOUT-1 with no match, the block times out.
- Pulses:
  - `done`, `timeout` and `load_err` are asserted only in the DONE cycle.
  - At most one of the three is asserted in any cycle.
- Priority when events coincide: `load_err`, then match, then timeout. A match on the last watchdog cycle yields `done`=1 and `timeout`=0.
- `start` is ignored while `busy`=1. There is no queueing; a `start` held high through DONE is re-accepted in IDLE.
- `preset`==`target`: match occurs on the first RUN edge.
- Width rule: compares are exact W-bit equality. The counter wrap (15→0 for W=4) needs no special handling.
- Reset, including mid-operation:
  - State returns to IDLE.
  - `load_out`, `busy`, `done`, `timeout` and `load_err` go to 0.
  - `data_out`, the captured registers and the watchdog go to 0.
  - The counter is not reloaded.

## Timing
- `start` sampled at edge k causes:
  - `busy`=1 and `load_out`=1 during cycle k→k+1.
  - The counter loads at edge k+1.
  - RUN spans from edge k+1; `count_in`=preset is first compared at edge k+2.
- Match:
  - If `count_in` first equals target when sampled at edge m in RUN, DONE spans m→m+1 with `done`=1.
  - `busy` falls at edge m+1.
- Timeout:
  - DONE is entered at the edge where the watchdog reaches TIMEOUT-1, which is TIMEOUT edges after edge k+1.
  - The earliest new `start` is accepted at the edge after DONE.

## Configuration
- Macro: `COUNT_LOADER_LOAD_CHECK_EN`.
- Defined:
  - On the first RUN edge (k+2), `count_in`≠preset sends the block to DONE with `load_err`=1.
  - A mismatch there takes priority over a match.
  - Latency is unchanged.
- Undefined:
  - No check is made and `load_err` is absent.
  - Behaviour is otherwise identical.

## Structure
- Package `count_loader_pkg` contains:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - the default W;
  - the watchdog width constant (8).
- Sub-module `count_watchdog`: has clear, enable, limit and expired; instantiated once.
- The remaining FSM, capture registers and compare logic live in `count_loader`.

## Test plan
- Wrap-around match: W=4, preset=13, target=2, driving a real loadable up-counter. Required: `load_out` pulse of exactly 1 cycle with `data_out`=13, then `done` pulse after count sequence 13,14,15,0,1,2; `timeout`=0.
- Timeout: counter held (never increments), preset=3, target=9, TIMEOUT=8. Required: `timeout` pulse 8 edges after LOAD exit; `done`=0; `busy` drops.
- Equal preset and target: preset=target=5. Required: `done` at edge k+2 and `busy` low after edge k+3.
- Reset mid-RUN: assert `rst` asynchronously mid-cycle during RUN. Required: all outputs 0 immediately without a clock edge; after release, `start` is accepted normally.
- Start ignored while busy: pulse `start` with preset=1 while RUN. Required: no second `load_out`; `data_out` stays at the first preset.
- `LOAD_CHECK_EN`: model forces `count_in`=7 after a load of 13. Required: `load_err` pulse at DONE with `done`=0. Repeating with a correct counter gives `load_err`=0.

Source files
------------

// File: rtl/count_loader_pkg.sv
// count_loader_pkg: shared types and constants for the count_loader sequencer.
package count_loader_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Default counter data width
   localparam int W_DEF = 4;

   // Watchdog counter width
   localparam int WD_W = 8;

endpackage

// File: rtl/count_loader_watchdog.sv
// count_watchdog: 8-bit RUN-cycle counter that flags when it sits on the limit.
module count_watchdog
   import count_loader_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_clear,
   input  logic            i_enable,
   input  logic [WD_W-1:0] i_limit,
   output logic            o_expired
);

   logic [WD_W-1:0] r_cnt;

   // Count enabled cycles; clear has priority so each RUN phase starts at zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = (r_cnt == i_limit);

endmodule

// File: rtl/count_loader.sv
// count_loader: programs a loadable up-counter with a preset, then waits for
// the counter to reach a target value or for the watchdog to expire.
// Optional load verification on the first RUN edge is enabled by defining
// COUNT_LOADER_LOAD_CHECK_EN (adds the o_load_err port).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for i_start; preset/target captured on accept
//   LOAD   | one cycle with o_load_out=1 driving the preset into the counter
//   RUN    | compare i_count_in against target every edge, watchdog running
//   DONE   | one cycle carrying the done/timeout/load_err pulse
module count_loader
   import count_loader_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int TIMEOUT = 32
)
(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [W-1:0] i_preset,
   input  logic [W-1:0] i_target,
   input  logic [W-1:0] i_count_in,
   output logic         o_load_out,
   output logic [W-1:0] o_data_out,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_timeout
`ifdef COUNT_LOADER_LOAD_CHECK_EN
   ,
   output logic         o_load_err
`endif
);

   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

   state_t       r_state;
   logic [W-1:0] r_target;
   logic         w_match;
   logic         w_expired;
   logic         w_wd_clear;
   logic         w_wd_en;
   logic         w_load_bad;

   assign w_match    = (i_count_in == r_target);
   assign w_wd_clear = (r_state == S_LOAD);
   assign w_wd_en    = (r_state == S_RUN);

`ifdef COUNT_LOADER_LOAD_CHECK_EN
   logic r_first;

   // Marks the first RUN cycle, the only one where the loaded value is checked.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_first <= 1'b0;
      end else begin
         r_first <= (r_state == S_LOAD);
      end
   end

   // o_data_out still holds the captured preset, so it doubles as the reference.
   assign w_load_bad = r_first && (i_count_in != o_data_out);

   // Load error pulse, registered alongside the RUN->DONE transition.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_load_err <= 1'b0;
      end else begin
         o_load_err <= (r_state == S_RUN) && w_load_bad;
      end
   end
`else
   assign w_load_bad = 1'b0;
`endif

   count_watchdog u_watchdog (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (w_wd_clear),
      .i_enable  (w_wd_en),
      .i_limit   (WD_LIMIT),
      .o_expired (w_expired)
   );

   // Sequencer FSM with registered outputs; load error beats match beats timeout.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_target   <= '0;
         o_load_out <= 1'b0;
         o_data_out <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_timeout  <= 1'b0;
      end else begin
         o_done    <= 1'b0;
         o_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state    <= S_LOAD;
                  o_load_out <= 1'b1;
                  o_busy     <= 1'b1;
                  o_data_out <= i_preset;
                  r_target   <= i_target;
               end
            end
            S_LOAD: begin
               r_state    <= S_RUN;
               o_load_out <= 1'b0;
            end
            S_RUN: begin
               if (w_load_bad) begin
                  r_state <= S_DONE;
               end else if (w_match) begin
                  r_state <= S_DONE;
                  o_done  <= 1'b1;
               end else if (w_expired) begin
                  r_state   <= S_DONE;
                  o_timeout <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               o_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_count_loader.sv
// tb_count_loader: directed bench for count_loader with a transaction-level
// reference model and a per-cycle output compare.
module tb_count_loader;

   localparam int W  = 4;
   localparam int TO = 8;
`ifdef COUNT_LOADER_LOAD_CHECK_EN
   localparam bit LC = 1'b1;
`else
   localparam bit LC = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] preset = '0;
   logic [W-1:0] target = '0;
   logic [W-1:0] cnt = '0;
   logic         cnt_en = 1'b0;
   logic         force_en = 1'b0;
   logic [W-1:0] force_val = '0;
   logic [W-1:0] count_in;
   logic         load_out;
   logic [W-1:0] data_out;
   logic         busy;
   logic         done;
   logic         timeout_o;
   logic         load_err;

   assign count_in = force_en ? force_val : cnt;

   count_loader #(.W(W), .TIMEOUT(TO)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_preset   (preset),
      .i_target   (target),
      .i_count_in (count_in),
      .o_load_out (load_out),
      .o_data_out (data_out),
      .o_busy     (busy),
      .o_done     (done),
      .o_timeout  (timeout_o)
`ifdef COUNT_LOADER_LOAD_CHECK_EN
      ,
      .o_load_err (load_err)
`endif
   );

`ifndef COUNT_LOADER_LOAD_CHECK_EN
   assign load_err = 1'b0;
`endif

   always #5 clk = ~clk;

   // Loadable up-counter on the far side of the sequencer (not reset).
   always @(posedge clk) begin
      if (load_out) cnt <= data_out;
      else if (cnt_en) cnt <= cnt + 1'b1;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Reference model: tracks edges since acceptance; RUN compare number r is
   // made on the (r+1)th edge after the accepting edge.
   int           m_age;
   bit           m_fin, m_busy, m_load, m_done, m_to, m_err;
   logic [W-1:0] m_data, m_tgt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_age = 0; m_fin = 0; m_busy = 0; m_load = 0;
         m_done = 0; m_to = 0; m_err = 0; m_data = '0; m_tgt = '0;
      end else begin
         m_done = 0; m_to = 0; m_err = 0;
         if (m_fin) begin
            m_fin = 0; m_busy = 0; m_age = 0;
         end else if (m_age == 0) begin
            if (start) begin
               m_age = 1; m_busy = 1; m_load = 1;
               m_data = preset; m_tgt = target;
            end
         end else begin
            m_load = 0;
            if (m_age >= 2) begin
               if (LC && (m_age - 1) == 1 && count_in != m_data) m_err = 1;
               else if (count_in == m_tgt) m_done = 1;
               else if ((m_age - 1) == TO) m_to = 1;
               if (m_err || m_done || m_to) m_fin = 1;
            end
            m_age++;
         end
      end
   end

   // Every-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      chk("cyc_load_out", int'(load_out), int'(m_load));
      chk("cyc_busy", int'(busy), int'(m_busy));
      chk("cyc_data_out", int'(data_out), int'(m_data));
      chk("cyc_done", int'(done), int'(m_done));
      chk("cyc_timeout", int'(timeout_o), int'(m_to));
      chk("cyc_load_err", int'(load_err), int'(m_err));
   end

   // One transaction: n counts negedges after the accepting edge (n=0 is LOAD).
   task automatic txn(input logic [W-1:0] p, input logic [W-1:0] t, input bit inc,
                      input int ign_at, output int n_evt, output int kind,
                      output int loads, output int d0, output int d_evt,
                      output int busy_after);
      @(negedge clk);
      preset = p; target = t; cnt_en = inc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_evt = -1; kind = 0; loads = 0; d0 = int'(data_out); d_evt = -1; busy_after = -1;
      for (int n = 0; n < 40; n++) begin
         if (n > 0) @(negedge clk);
         if (n == ign_at) begin start = 1'b1; preset = 4'd1; end
         if (n == ign_at + 1) start = 1'b0;
         if (load_out) loads++;
         if (done || timeout_o || load_err) begin
            n_evt = n;
            kind  = int'(done) + 2 * int'(timeout_o) + 4 * int'(load_err);
            d_evt = int'(data_out);
            break;
         end
      end
      start = 1'b0;
      if (n_evt < 0) begin
         errors++;
         $display("FAIL txn_bound actual=no_event required=event_within_40");
      end else begin
         @(negedge clk);
         busy_after = int'(busy);
      end
      cnt_en = 1'b0;
   endtask

   int n_evt, kind, loads, d0, d_evt, busy_after;

   initial begin
      #100000;
      $display("FAIL global_time_limit actual=expired required=finish");
      $fatal(1, "time limit");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_load_out", int'(load_out), 0);
      chk("rst_data_out", int'(data_out), 0);
      rst = 1'b0;

      // Wrap-around match 13,14,15,0,1,2
      txn(4'd13, 4'd2, 1'b1, -5, n_evt, kind, loads, d0, d_evt, busy_after);
      chk("wrap_lat", n_evt, 7);
      chk("wrap_kind", kind, 1);
      chk("wrap_loads", loads, 1);
      chk("wrap_data", d0, 13);
      chk("wrap_busy_after", busy_after, 0);

      // Timeout with held counter
      txn(4'd3, 4'd9, 1'b0, -5, n_evt, kind, loads, d0, d_evt, busy_after);
      chk("to_lat", n_evt, 9);
      chk("to_kind", kind, 2);
      chk("to_busy_after", busy_after, 0);

      // Equal preset and target
      txn(4'd5, 4'd5, 1'b1, -5, n_evt, kind, loads, d0, d_evt, busy_after);
      chk("eq_lat", n_evt, 2);
      chk("eq_kind", kind, 1);
      chk("eq_busy_after", busy_after, 0);

      // Start pulsed while busy is ignored
      txn(4'd4, 4'd10, 1'b1, 2, n_evt, kind, loads, d0, d_evt, busy_after);
      chk("ign_lat", n_evt, 8);
      chk("ign_kind", kind, 1);
      chk("ign_loads", loads, 1);
      chk("ign_data", d_evt, 4);

      // Match on the last watchdog cycle wins over timeout
      txn(4'd4, 4'd11, 1'b1, -5, n_evt, kind, loads, d0, d_evt, busy_after);
      chk("last_lat", n_evt, 9);
      chk("last_kind", kind, 1);

      // Asynchronous reset mid-RUN
      @(negedge clk);
      preset = 4'd13; target = 4'd2; cnt_en = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_load_out", int'(load_out), 0);
      chk("arst_data_out", int'(data_out), 0);
      chk("arst_pulses", int'(done) + int'(timeout_o) + int'(load_err), 0);
      @(negedge clk);
      rst = 1'b0;
      cnt_en = 1'b0;
      txn(4'd6, 4'd8, 1'b1, -5, n_evt, kind, loads, d0, d_evt, busy_after);
      chk("post_rst_lat", n_evt, 4);
      chk("post_rst_kind", kind, 1);

`ifdef COUNT_LOADER_LOAD_CHECK_EN
      // Counter stuck at 7 after a load of 13
      force_en = 1'b1; force_val = 4'd7;
      txn(4'd13, 4'd2, 1'b0, -5, n_evt, kind, loads, d0, d_evt, busy_after);
      chk("lc_lat", n_evt, 2);
      chk("lc_kind", kind, 4);
      // Mismatch beats a coincident match
      txn(4'd13, 4'd7, 1'b0, -5, n_evt, kind, loads, d0, d_evt, busy_after);
      chk("lc_prio_kind", kind, 4);
      force_en = 1'b0;
      txn(4'd13, 4'd2, 1'b1, -5, n_evt, kind, loads, d0, d_evt, busy_after);
      chk("lc_ok_kind", kind, 1);
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
